// File: rtl/ptr_sync_pkg.sv
// ----------------------------------------------------------------------------
// ptr_sync_pkg
//
// Purpose : shared constants and helper functions for the Gray pointer
//           synchroniser (ptr_sync) and its flop chain (sync_chain).
//
// Contents:
//   MIN_SYNC_STAGES / MAX_SYNC_STAGES : legal synchroniser depth range.
//   MAX_PTR_WIDTH                     : widest pointer the helpers handle.
//   gray2bin()                        : Gray to binary conversion.
//   multi_bit_change()                : 1 when a XOR difference has >1 bit set.
// ----------------------------------------------------------------------------
package ptr_sync_pkg;

    localparam int unsigned MIN_SYNC_STAGES = 2;
    localparam int unsigned MAX_SYNC_STAGES = 4;
    localparam int unsigned MAX_PTR_WIDTH   = 32;

    // Callers zero-extend their pointer to MAX_PTR_WIDTH. The leading zeros
    // propagate through the MSB-first XOR recurrence unchanged, so the low
    // ADDR_WIDTH+1 bits of the result are the conversion of the real pointer.
    function automatic logic [MAX_PTR_WIDTH-1:0] gray2bin(
        input logic [MAX_PTR_WIDTH-1:0] gray
    );
        logic [MAX_PTR_WIDTH-1:0] bin;
        bin = '0;
        bin[MAX_PTR_WIDTH-1] = gray[MAX_PTR_WIDTH-1];
        for (int unsigned k = 1; k < MAX_PTR_WIDTH; k++) begin
            bin[MAX_PTR_WIDTH-1-k] = bin[MAX_PTR_WIDTH-k] ^ gray[MAX_PTR_WIDTH-1-k];
        end
        return bin;
    endfunction

    // Clearing the lowest set bit leaves something only if two or more
    // bits were set.
    function automatic logic multi_bit_change(
        input logic [MAX_PTR_WIDTH-1:0] diff
    );
        return (diff & (diff - 1'b1)) != '0;
    endfunction

endpackage : ptr_sync_pkg

// File: rtl/sync_chain.sv
// ----------------------------------------------------------------------------
// sync_chain
//
// Purpose : plain N-stage flop chain for bringing asynchronous signals into
//           the i_clk domain. No logic before the first stage, all stages
//           reset to zero. Usable for buses of Gray code or single-bit
//           control signals.
//
// Parameters:
//   WIDTH  : data width.
//   STAGES : number of flops in the chain (>= 1).
//
// Ports:
//   i_clk   in   destination clock
//   i_rst_n in   asynchronous active-low reset
//   i_d     in   asynchronous data [WIDTH-1:0]
//   o_q     out  last chain stage  [WIDTH-1:0]
// ----------------------------------------------------------------------------
module sync_chain #(
    parameter int unsigned WIDTH  = 1,
    parameter int unsigned STAGES = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    if (STAGES < 1) begin : g_bad_stages
        $error("sync_chain: STAGES must be at least 1");
    end

    logic [WIDTH-1:0] r_stage [STAGES];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned i = 0; i < STAGES; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= i_d;
            for (int unsigned i = 1; i < STAGES; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_q = r_stage[STAGES-1];

endmodule : sync_chain

// File: rtl/ptr_sync.sv
// ----------------------------------------------------------------------------
// ptr_sync
//
// Purpose : brings a Gray-coded FIFO pointer from a foreign clock domain into
//           sync_clk through SYNC_STAGES flops, then provides a registered
//           binary copy, a change strobe and the binary advance since the
//           previous sample, for direct use by full/empty and level logic.
//
// Parameters:
//   ADDR_WIDTH  : FIFO address width; pointers are ADDR_WIDTH+1 bits.
//   SYNC_STAGES : synchroniser depth, 2..4 (other values fail elaboration).
//
// Ports:
//   sync_clk   in   destination-domain clock
//   rst_n      in   asynchronous active-low reset
//   ori_ptr    in   Gray pointer from the source domain (asynchronous)
//   clr_err    in   synchronous clear of gray_err
//   sync_ptr   out  synchronised Gray pointer (last chain stage)
//   sync_bin   out  registered binary equivalent of sync_ptr
//   ptr_chg    out  one-cycle pulse with sync_bin when the sample changed
//   ptr_delta  out  registered binary advance, modulo 2^(ADDR_WIDTH+1)
//   gray_err   out  sticky: consecutive samples differed in more than one bit
//
// Build option:
//   PTR_SYNC_GRAY_CHK_EN : when defined, builds the Gray-step checker driving
//                          gray_err. When undefined, gray_err is tied low and
//                          clr_err is ignored.
// ----------------------------------------------------------------------------
module ptr_sync
    import ptr_sync_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                sync_clk,
    input  logic                rst_n,
    input  logic [ADDR_WIDTH:0] ori_ptr,
    input  logic                clr_err,
    output logic [ADDR_WIDTH:0] sync_ptr,
    output logic [ADDR_WIDTH:0] sync_bin,
    output logic                ptr_chg,
    output logic [ADDR_WIDTH:0] ptr_delta,
    output logic                gray_err
);

    localparam int unsigned PTR_W = ADDR_WIDTH + 1;

    if (SYNC_STAGES < MIN_SYNC_STAGES || SYNC_STAGES > MAX_SYNC_STAGES) begin : g_bad_stages
        $error("ptr_sync: SYNC_STAGES must be in the range 2..4");
    end

    if (PTR_W > MAX_PTR_WIDTH) begin : g_bad_width
        $error("ptr_sync: ADDR_WIDTH+1 exceeds MAX_PTR_WIDTH");
    end

    logic [PTR_W-1:0] w_sync_gray;
    logic [PTR_W-1:0] w_bin_next;
    logic [PTR_W-1:0] w_gray_diff;

    logic [PTR_W-1:0] r_prev_gray;
    logic [PTR_W-1:0] r_sync_bin;
    logic [PTR_W-1:0] r_delta;
    logic             r_chg;

    sync_chain #(
        .WIDTH  (PTR_W),
        .STAGES (SYNC_STAGES)
    ) u_chain (
        .i_clk   (sync_clk),
        .i_rst_n (rst_n),
        .i_d     (ori_ptr),
        .o_q     (w_sync_gray)
    );

    assign w_bin_next  = PTR_W'(gray2bin(MAX_PTR_WIDTH'(w_sync_gray)));
    assign w_gray_diff = w_sync_gray ^ r_prev_gray;

    // r_sync_bin doubles as the previous binary sample, so the subtraction
    // below is new minus previous; truncation handles pointer wrap.
    always_ff @(posedge sync_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev_gray <= '0;
            r_sync_bin  <= '0;
            r_delta     <= '0;
            r_chg       <= 1'b0;
        end else begin
            r_prev_gray <= w_sync_gray;
            r_sync_bin  <= w_bin_next;
            r_delta     <= w_bin_next - r_sync_bin;
            r_chg       <= (w_gray_diff != '0);
        end
    end

`ifdef PTR_SYNC_GRAY_CHK_EN
    logic r_gray_err;

    // A fresh illegal step takes priority over a clear in the same cycle.
    always_ff @(posedge sync_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gray_err <= 1'b0;
        end else if (multi_bit_change(MAX_PTR_WIDTH'(w_gray_diff))) begin
            r_gray_err <= 1'b1;
        end else if (clr_err) begin
            r_gray_err <= 1'b0;
        end
    end

    assign gray_err = r_gray_err;
`else
    logic w_clr_err_unused;

    assign w_clr_err_unused = clr_err;
    assign gray_err         = 1'b0;
`endif

    assign sync_ptr  = w_sync_gray;
    assign sync_bin  = r_sync_bin;
    assign ptr_chg   = r_chg;
    assign ptr_delta = r_delta;

endmodule : ptr_sync

// File: tb/tb_ptr_sync.sv
// ----------------------------------------------------------------------------
// tb_ptr_sync
//
// Purpose : self-checking bench for ptr_sync. Two instances (SYNC_STAGES 2
//           and 3) share the same stimulus. Every pointer change pushes the
//           expected (cycle, sync_bin, ptr_delta) into a per-instance queue;
//           a negedge monitor pops on each ptr_chg pulse and compares.
//           Directed checks cover reset state, chain latency, gray_err
//           stickiness/clear priority and mid-stream reset.
// ----------------------------------------------------------------------------
module tb_ptr_sync;

    localparam int unsigned AW = 10;
    localparam int unsigned W  = AW + 1;

`ifdef PTR_SYNC_GRAY_CHK_EN
    localparam logic CHK = 1'b1;
`else
    localparam logic CHK = 1'b0;
`endif

    typedef struct {
        int unsigned  at_cyc;
        logic [W-1:0] bin;
        logic [W-1:0] delta;
    } exp_t;

    logic         clk     = 1'b0;
    logic         rst_n   = 1'b0;
    logic         clr_err = 1'b0;
    logic [W-1:0] ori     = '0;

    logic [W-1:0] s2_ptr, s2_bin, s2_delta;
    logic         s2_chg, s2_err;
    logic [W-1:0] s3_ptr, s3_bin, s3_delta;
    logic         s3_chg, s3_err;

    int unsigned  cyc      = 0;
    int unsigned  n_checks = 0;
    int unsigned  n_fail   = 0;
    logic [W-1:0] model_bin = '0;
    exp_t         q2[$];
    exp_t         q3[$];

    ptr_sync #(.ADDR_WIDTH(AW), .SYNC_STAGES(2)) u_dut2 (
        .sync_clk  (clk),
        .rst_n     (rst_n),
        .ori_ptr   (ori),
        .clr_err   (clr_err),
        .sync_ptr  (s2_ptr),
        .sync_bin  (s2_bin),
        .ptr_chg   (s2_chg),
        .ptr_delta (s2_delta),
        .gray_err  (s2_err)
    );

    ptr_sync #(.ADDR_WIDTH(AW), .SYNC_STAGES(3)) u_dut3 (
        .sync_clk  (clk),
        .rst_n     (rst_n),
        .ori_ptr   (ori),
        .clr_err   (clr_err),
        .sync_ptr  (s3_ptr),
        .sync_bin  (s3_bin),
        .ptr_chg   (s3_chg),
        .ptr_delta (s3_delta),
        .gray_err  (s3_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [W-1:0] to_gray(input logic [W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drive a binary pointer value (as Gray) just after a rising edge; the
    // value is stable before edge d+1, so sync_bin shows it after edge
    // d+1+SYNC_STAGES.
    task automatic drive_bin(input logic [W-1:0] b, output int unsigned d);
        @(posedge clk);
        #2;
        ori = to_gray(b);
        d   = cyc;
        if (b != model_bin) begin
            q2.push_back('{at_cyc: d + 3, bin: b, delta: b - model_bin});
            q3.push_back('{at_cyc: d + 4, bin: b, delta: b - model_bin});
        end
        model_bin = b;
    endtask

    task automatic wait_neg(input int unsigned target);
        @(negedge clk);
        for (int k = 0; k < 64 && cyc < target; k++) @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_d2_sync_ptr"},  32'(s2_ptr),   0);
        chk({tag, "_d2_sync_bin"},  32'(s2_bin),   0);
        chk({tag, "_d2_ptr_chg"},   32'(s2_chg),   0);
        chk({tag, "_d2_ptr_delta"}, 32'(s2_delta), 0);
        chk({tag, "_d2_gray_err"},  32'(s2_err),   0);
        chk({tag, "_d3_sync_ptr"},  32'(s3_ptr),   0);
        chk({tag, "_d3_sync_bin"},  32'(s3_bin),   0);
        chk({tag, "_d3_ptr_chg"},   32'(s3_chg),   0);
        chk({tag, "_d3_ptr_delta"}, 32'(s3_delta), 0);
        chk({tag, "_d3_gray_err"},  32'(s3_err),   0);
    endtask

    // Scoreboard monitors
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            while (q2.size() > 0 && q2[0].at_cyc < cyc) begin
                e = q2.pop_front();
                chk("d2_chg_missing_cycle", cyc, e.at_cyc);
            end
            if (s2_chg) begin
                if (q2.size() == 0) begin
                    chk("d2_spurious_chg_queue", q2.size(), 1);
                end else begin
                    e = q2.pop_front();
                    chk("d2_chg_cycle", cyc, e.at_cyc);
                    chk("d2_sync_bin", 32'(s2_bin), 32'(e.bin));
                    chk("d2_ptr_delta", 32'(s2_delta), 32'(e.delta));
                end
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            while (q3.size() > 0 && q3[0].at_cyc < cyc) begin
                e = q3.pop_front();
                chk("d3_chg_missing_cycle", cyc, e.at_cyc);
            end
            if (s3_chg) begin
                if (q3.size() == 0) begin
                    chk("d3_spurious_chg_queue", q3.size(), 1);
                end else begin
                    e = q3.pop_front();
                    chk("d3_chg_cycle", cyc, e.at_cyc);
                    chk("d3_sync_bin", 32'(s3_bin), 32'(e.bin));
                    chk("d3_ptr_delta", 32'(s3_delta), 32'(e.delta));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned d;

        // Reset: a non-zero input must not reach the outputs while held.
        ori = to_gray(11'h7FF);
        #23;
        chk_all_zero("reset");
        ori = '0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // Latency step 0 -> 1
        drive_bin(11'd1, d);
        wait_neg(d + 1);
        chk("lat_d2_sync_ptr_e1", 32'(s2_ptr), 0);
        wait_neg(d + 2);
        chk("lat_d2_sync_ptr_e2", 32'(s2_ptr), 1);
        chk("lat_d3_sync_ptr_e2", 32'(s3_ptr), 0);
        wait_neg(d + 3);
        chk("lat_d3_sync_ptr_e3", 32'(s3_ptr), 1);
        wait_neg(d + 4);
        chk("lat_d2_chg_e4",   32'(s2_chg),   0);
        chk("lat_d2_delta_e4", 32'(s2_delta), 0);
        wait_neg(d + 5);
        chk("lat_d3_chg_e5",   32'(s3_chg),   0);
        chk("lat_d3_delta_e5", 32'(s3_delta), 0);

        // Counting, one value per cycle
        for (int unsigned b = 2; b <= 20; b++) drive_bin(W'(b), d);
        wait_neg(d + 6);
        chk("count_d2_sync_bin", 32'(s2_bin), 20);
        chk("count_d3_sync_bin", 32'(s3_bin), 20);
        chk("count_d2_gray_err", 32'(s2_err), 0);
        chk("count_d3_gray_err", 32'(s3_err), 0);

        // Wrap 2046 -> 2047 -> 0
        drive_bin(11'd2046, d);
        drive_bin(11'd2047, d);
        drive_bin(11'd0, d);
        wait_neg(d + 6);
        chk("wrap_d2_sync_bin", 32'(s2_bin), 0);
        chk("wrap_d3_sync_ptr", 32'(s3_ptr), 0);

        // Error: Gray 0 -> Gray 3 (two bits)
        drive_bin(11'd2, d);
        wait_neg(d + 3);
        chk("err_d2_set", 32'(s2_err), 32'(CHK));
        wait_neg(d + 4);
        chk("err_d3_set", 32'(s3_err), 32'(CHK));
        wait_neg(d + 7);
        chk("err_d2_sticky", 32'(s2_err), 32'(CHK));

        // Clear coinciding with another bad step (Gray 3 -> 0) at d2
        drive_bin(11'd0, d);
        repeat (2) @(posedge clk);
        #2;
        clr_err = 1'b1;
        @(posedge clk);
        #2;
        clr_err = 1'b0;
        wait_neg(d + 3);
        chk("err_d2_set_beats_clr", 32'(s2_err), 32'(CHK));
        wait_neg(d + 4);
        chk("err_d3_reset_after_clr", 32'(s3_err), 32'(CHK));

        // Clear alone
        repeat (4) @(posedge clk);
        #2;
        clr_err = 1'b1;
        @(posedge clk);
        #2;
        clr_err = 1'b0;
        @(negedge clk);
        chk("err_d2_cleared", 32'(s2_err), 0);
        chk("err_d3_cleared", 32'(s3_err), 0);

        // Reset mid-stream
        drive_bin(11'd10, d);
        drive_bin(11'd11, d);
        drive_bin(11'd12, d);
        drive_bin(11'd13, d);
        #1;
        rst_n = 1'b0;
        #1;
        chk_all_zero("midrst");
        q2.delete();
        q3.delete();
        model_bin = '0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        d = cyc;
        q2.push_back('{at_cyc: d + 3, bin: 11'd13, delta: 11'd13});
        q3.push_back('{at_cyc: d + 4, bin: 11'd13, delta: 11'd13});
        model_bin = 11'd13;
        drive_bin(11'd14, d);
        wait_neg(d + 8);
        chk("midrst_d2_sync_bin", 32'(s2_bin), 14);
        chk("midrst_d3_sync_bin", 32'(s3_bin), 14);

        chk("final_q2_empty", q2.size(), 0);
        chk("final_q3_empty", q3.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_ptr_sync
